// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit with in-order buffer and redirect flush
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   fifo_pc_q   [DEPTH];

  logic          accept;
  logic          rsp_take;
  logic          push;
  logic          pop;
  logic [CW:0]   in_use;
  logic [31:0]   rsp_pc;
  logic          unused_redirect_lsbs;

  // The two low redirect bits are dropped: fetch is always word aligned.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Issue and delivery handshakes; a redirect suppresses both in its own cycle.
  always_comb begin
    in_use         = {1'b0, outst_q} + {1'b0, count_q};
    imem_req_valid = (state_q == FETCH) && !redirect_valid && (in_use < (CW+1)'(DEPTH));
    instr_valid    = (state_q == FETCH) && !redirect_valid && (count_q != '0);
    accept         = imem_req_valid && imem_req_ready;
    rsp_take       = imem_rsp_valid && (outst_q != '0) && (state_q != IDLE);
    push           = rsp_take && (state_q == FETCH) && !redirect_valid;
    pop            = instr_valid && instr_ready;
    // In FETCH all in-flight requests are consecutive words ending just below pc_q.
    rsp_pc         = pc_q - (32'(outst_q) << 2);
  end

  assign imem_addr = pc_q;
  assign instr     = fifo_data_q[head_q];
  assign instr_pc  = fifo_pc_q[head_q];

  // Next-state for PC, in-flight count, buffer pointers and FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    outst_d = outst_q;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;

    if (accept) pc_d = pc_q + 32'd4;

    case ({accept, rsp_take})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase

    if (redirect_valid && (state_q != IDLE)) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (push) tail_d = ptr_inc(tail_q);
      if (pop)  head_d = ptr_inc(head_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (redirect_valid && (outst_d != '0)) state_d = FLUSH;
      FLUSH:   if (!redirect_valid && (outst_d == '0)) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // State registers and buffer storage, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      outst_q <= '0;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      if (push) begin
        fifo_data_q[tail_q] <= imem_rsp_data;
        fifo_pc_q[tail_q]   <= rsp_pc;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_ready = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  instr_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  // Second instance for the wrap-around reset PC.
  logic        r2_rst_n = 1'b0;
  logic        r2_req_valid;
  logic [31:0] r2_addr;
  logic        r2_instr_valid;
  logic [31:0] r2_instr;
  logic [31:0] r2_instr_pc;

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst_n(r2_rst_n),
    .imem_req_valid(r2_req_valid), .imem_req_ready(1'b1), .imem_addr(r2_addr),
    .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_valid(r2_instr_valid), .instr_ready(1'b1), .instr(r2_instr), .instr_pc(r2_instr_pc)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} + 32'h0101_0101;
  endfunction

  // Reference model: mode 0 idle, 1 fetch, 2 flush; queues of in-flight PCs and buffered {data,pc}.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_infl[$];
  logic [63:0] m_buf[$];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t       mem_q[$];
  int          cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  logic [31:0] acc_log[$];
  logic [31:0] del_log[$];

  task automatic step(input bit rst, input bit rdy, input bit irdy, input bit rdir,
                      input logic [31:0] rpc, input bit spur);
    bit          e_req, e_iv, mem_hit, rsp_ok;
    logic [31:0] a;
    mreq_t       mr;
    @(negedge clk);
    cyc++;
    rst_n          = rst;
    imem_req_ready = rdy;
    instr_ready    = irdy;
    redirect_valid = rdir;
    redirect_pc    = rpc;
    mem_hit = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    if (mem_hit) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memfn(mem_q[0].addr);
    end else if (spur) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    if (!rst) begin
      check1("rst_req_valid", imem_req_valid, 1'b0);
      check32("rst_imem_addr", imem_addr, RPC);
      check1("rst_instr_valid", instr_valid, 1'b0);
      check32("rst_instr", instr, 32'h0);
      check32("rst_instr_pc", instr_pc, 32'h0);
      m_mode = 0;
      m_pc   = RPC;
      m_infl.delete();
      m_buf.delete();
      if (mem_hit) void'(mem_q.pop_front());
      return;
    end
    e_req = (m_mode == 1) && !rdir && (m_infl.size() + m_buf.size() < DEPTH);
    e_iv  = (m_mode == 1) && !rdir && (m_buf.size() > 0);
    check1("req_valid", imem_req_valid, e_req);
    check32("imem_addr", imem_addr, m_pc);
    check1("instr_valid", instr_valid, e_iv);
    if (e_iv) begin
      check32("instr_pc", instr_pc, m_buf[0][31:0]);
      check32("instr", instr, m_buf[0][63:32]);
    end
    if (imem_req_valid && rdy) begin
      mr.addr = imem_addr;
      mr.due  = cyc + int'($urandom_range(lat_max, lat_min));
      mem_q.push_back(mr);
      acc_log.push_back(imem_addr);
    end
    if (mem_hit) void'(mem_q.pop_front());
    if (m_mode == 0) begin
      m_mode = 1;
      return;
    end
    rsp_ok = imem_rsp_valid && (m_infl.size() > 0);
    if (e_iv && irdy) begin
      del_log.push_back(m_buf[0][31:0]);
      void'(m_buf.pop_front());
    end
    if (rsp_ok) begin
      a = m_infl.pop_front();
      if (m_mode == 1 && !rdir) m_buf.push_back({imem_rsp_data, a});
    end
    if (e_req && rdy) begin
      m_infl.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    if (rdir) begin
      m_buf.delete();
      m_pc   = {rpc[31:2], 2'b00};
      m_mode = (m_mode == 2 || m_infl.size() > 0) ? 2 : 1;
    end else if (m_mode == 2 && m_infl.size() == 0) begin
      m_mode = 1;
    end
  endtask

  task automatic do_reset();
    mem_q.delete();
    acc_log.delete();
    del_log.delete();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic run(input int n, input bit rdy, input bit irdy);
    for (int i = 0; i < n; i++) step(1'b1, rdy, irdy, 1'b0, 32'h0, 1'b0);
  endtask

  typedef struct {
    logic        rdy;
    logic        rspv;
    logic [31:0] rspd;
    logic        rdir;
    logic [31:0] rpc;
    logic        irdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic [31:0] e_ins;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic rspv, input logic [31:0] rspd,
                              input logic rdir, input logic [31:0] rpc, input logic irdy,
                              input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                              input logic [31:0] e_ipc, input logic [31:0] e_ins);
    vec_t v;
    v.rdy = rdy; v.rspv = rspv; v.rspd = rspd; v.rdir = rdir; v.rpc = rpc; v.irdy = irdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_ipc = e_ipc; v.e_ins = e_ins;
    return v;
  endfunction

  vec_t vt[15];

  initial begin
    int acc_before;

    vt[0]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b0, 32'h000, 1'b0, 32'h000, 32'h0);
    vt[1]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h000, 1'b0, 32'h000, 32'h0);
    vt[2]  = mk(1'b1, 1'b1, 32'hA000_0000, 1'b0, 32'h0,   1'b1, 1'b1, 32'h004, 1'b0, 32'h000, 32'h0);
    vt[3]  = mk(1'b1, 1'b1, 32'hA000_0004, 1'b0, 32'h0,   1'b1, 1'b0, 32'h008, 1'b1, 32'h000, 32'hA000_0000);
    vt[4]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h008, 1'b1, 32'h004, 32'hA000_0004);
    vt[5]  = mk(1'b1, 1'b1, 32'hA000_0008, 1'b0, 32'h0,   1'b1, 1'b1, 32'h00C, 1'b0, 32'h000, 32'h0);
    vt[6]  = mk(1'b1, 1'b1, 32'hA000_000C, 1'b0, 32'h0,   1'b0, 1'b0, 32'h010, 1'b1, 32'h008, 32'hA000_0008);
    vt[7]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b0, 1'b0, 32'h010, 1'b1, 32'h008, 32'hA000_0008);
    vt[8]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b0, 32'h010, 1'b1, 32'h008, 32'hA000_0008);
    vt[9]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h010, 1'b1, 32'h00C, 32'hA000_000C);
    vt[10] = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h010, 1'b0, 32'h000, 32'h0);
    vt[11] = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h203, 1'b1, 1'b0, 32'h010, 1'b0, 32'h000, 32'h0);
    vt[12] = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, 32'h000, 32'h0);
    vt[13] = mk(1'b1, 1'b1, 32'hA000_0200, 1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 1'b0, 32'h000, 32'h0);
    vt[14] = mk(1'b1, 1'b1, 32'hA000_0204, 1'b0, 32'h0,   1'b1, 1'b0, 32'h208, 1'b1, 32'h200, 32'hA000_0200);

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    #1;
    check1("init_req_valid", imem_req_valid, 1'b0);
    check32("init_imem_addr", imem_addr, RPC);
    check1("init_instr_valid", instr_valid, 1'b0);
    check32("init_instr", instr, 32'h0);
    check32("init_instr_pc", instr_pc, 32'h0);

    // Cycle-exact startup, stall, request hold and redirect table.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rst_n          = 1'b1;
      imem_req_ready = vt[i].rdy;
      imem_rsp_valid = vt[i].rspv;
      imem_rsp_data  = vt[i].rspd;
      redirect_valid = vt[i].rdir;
      redirect_pc    = vt[i].rpc;
      instr_ready    = vt[i].irdy;
      #1;
      check1($sformatf("vec%0d req_valid", i), imem_req_valid, vt[i].e_req);
      check32($sformatf("vec%0d imem_addr", i), imem_addr, vt[i].e_addr);
      check1($sformatf("vec%0d instr_valid", i), instr_valid, vt[i].e_iv);
      if (vt[i].e_iv) begin
        check32($sformatf("vec%0d instr_pc", i), instr_pc, vt[i].e_ipc);
        check32($sformatf("vec%0d instr", i), instr, vt[i].e_ins);
      end
    end

    // Wrap of the fetch PC from 0xFFFF_FFFC.
    @(negedge clk);
    #1;
    check32("wrap_rst_addr", r2_addr, 32'hFFFF_FFFC);
    r2_rst_n = 1'b1;
    #1;
    check1("wrap_idle_req", r2_req_valid, 1'b0);
    @(negedge clk);
    #1;
    check1("wrap_req1_valid", r2_req_valid, 1'b1);
    check32("wrap_req1_addr", r2_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    #1;
    check1("wrap_req2_valid", r2_req_valid, 1'b1);
    check32("wrap_req2_addr", r2_addr, 32'h0000_0000);

    // Downstream stall: two requests, then in-order delivery.
    lat_min = 1; lat_max = 1;
    do_reset();
    run(11, 1'b1, 1'b0);
    check32("stall_req_count", 32'(acc_log.size()), 32'd2);
    run(8, 1'b1, 1'b1);
    check32("stall_del0", (del_log.size() > 0) ? del_log[0] : 32'hDEAD_BEEF, 32'h0);
    check32("stall_del1", (del_log.size() > 1) ? del_log[1] : 32'hDEAD_BEEF, 32'h4);

    // Redirect with two requests in flight drops both responses.
    lat_min = 3; lat_max = 3;
    do_reset();
    for (int i = 0; i < 20 && m_infl.size() != 2; i++) run(1, 1'b1, 1'b1);
    check32("flush_inflight", 32'(m_infl.size()), 32'd2);
    acc_before = acc_log.size();
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
    for (int i = 0; i < 40 && del_log.size() == 0; i++) run(1, 1'b1, 1'b1);
    check32("flush_next_addr", (acc_log.size() > acc_before) ? acc_log[acc_before] : 32'hDEAD_BEEF, 32'h100);
    check32("flush_first_pc", (del_log.size() > 0) ? del_log[0] : 32'hDEAD_BEEF, 32'h100);

    // Back-to-back redirects while flushing: the last one wins.
    lat_min = 4; lat_max = 4;
    do_reset();
    for (int i = 0; i < 20 && m_infl.size() != 2; i++) run(1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 1'b0);
    for (int i = 0; i < 40 && del_log.size() == 0; i++) run(1, 1'b1, 1'b1);
    check32("redir2_first_pc", (del_log.size() > 0) ? del_log[0] : 32'hDEAD_BEEF, 32'h300);

    // Reset while a request is held; late and spurious responses are ignored.
    lat_min = 2; lat_max = 2;
    do_reset();
    run(2, 1'b1, 1'b1);
    run(1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    del_log.delete();
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    run(10, 1'b1, 1'b1);
    check32("rstmid_first_pc", (del_log.size() > 0) ? del_log[0] : 32'hDEAD_BEEF, 32'h0);

    // Randomized traffic against the model.
    lat_min = 1; lat_max = 3;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      step(1'b1,
           $urandom_range(3, 0) != 0,
           $urandom_range(3, 0) != 0,
           $urandom_range(19, 0) == 0,
           $urandom,
           (mem_q.size() == 0) && ($urandom_range(15, 0) == 0));
    end
    check1("rand_progress", del_log.size() > 100, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
